// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the core's IFU and LSU ports.
// LSU-priority arbitration, one outstanding access, fixed response latency.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        fault
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  logic [31:0]   mem_q [DEPTH_WORDS];
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          lsu_sel_q, wen_q;
  logic [31:0]   addr_q, wdata_q;
  logic [1:0]    size_q;
  logic [3:0]    wmask_q;
  logic          ifu_resp_q, lsu_resp_q, fault_q;
  logic [31:0]   ifu_rdata_q, lsu_rdata_q;

  logic          any_req, cur_lsu, cur_wen, bad, enter_resp, do_store;
  logic [31:0]   cur_addr, cur_wdata, off, rd_word, rd_shift, rd_data;
  logic [1:0]    cur_size, lane;
  logic [3:0]    cur_wmask, byte_en;
  logic [AW-1:0] idx;

  // While IDLE the live request is used so a LATENCY of 1 can respond from the accept edge.
  always_comb begin
    any_req = ifu_reqValid | lsu_reqValid;
    if (state_q == S_IDLE) begin
      cur_lsu   = lsu_reqValid;
      cur_addr  = lsu_reqValid ? lsu_addr : ifu_addr;
      cur_size  = lsu_reqValid ? lsu_size : 2'd2;
      cur_wen   = lsu_reqValid & lsu_wen;
      cur_wdata = lsu_wdata;
      cur_wmask = lsu_wmask;
    end else begin
      cur_lsu   = lsu_sel_q;
      cur_addr  = addr_q;
      cur_size  = size_q;
      cur_wen   = wen_q;
      cur_wdata = wdata_q;
      cur_wmask = wmask_q;
    end
  end

  assign off        = cur_addr - BASE_ADDR;
  assign idx        = off[AW+1:2];
  assign lane       = off[1:0];
  assign bad        = (|off[31:AW+2]) | (cur_size == 2'd3) |
                      ((cur_size == 2'd1) & lane[0]) |
                      ((cur_size == 2'd2) & (lane != 2'd0));
  assign enter_resp = ((state_q == S_IDLE) && any_req && (CNT_INIT == '0)) ||
                      ((state_q == S_WAIT) && (cnt_q == CNT_ONE));
  assign rd_word    = mem_q[idx];
  assign rd_shift   = rd_word >> {lane, 3'b000};
  assign byte_en    = cur_wmask << lane;
  assign do_store   = enter_resp & cur_wen & ~bad & ~reset;

  always_comb begin
    case (cur_size)
      2'd0:    rd_data = {24'd0, rd_shift[7:0]};
      2'd1:    rd_data = {16'd0, rd_shift[15:0]};
      default: rd_data = rd_shift;
    endcase
  end

  always @(posedge clock) begin
    if (do_store) begin
      for (int j = 0; j < 4; j++) begin
        if (byte_en[j]) mem_q[idx][8*j +: 8] <= cur_wdata[8*j +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
      fault_q     <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      ifu_resp_q <= 1'b0;
      lsu_resp_q <= 1'b0;
      fault_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            lsu_sel_q <= cur_lsu;
            addr_q    <= cur_addr;
            size_q    <= cur_size;
            wen_q     <= cur_wen;
            wdata_q   <= cur_wdata;
            wmask_q   <= cur_wmask;
            cnt_q     <= CNT_INIT;
            state_q   <= (CNT_INIT == '0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= S_RESP;
        end
        default: state_q <= S_IDLE;
      endcase
      if (enter_resp) begin
        fault_q <= bad;
        if (cur_lsu) begin
          lsu_resp_q  <= 1'b1;
          lsu_rdata_q <= bad ? '0 : rd_data;
        end else begin
          ifu_resp_q  <= 1'b1;
          ifu_rdata_q <= bad ? '0 : rd_data;
        end
      end
    end
  end

  assign ifu_respValid = ifu_resp_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_respValid = lsu_resp_q;
  assign lsu_rdata     = lsu_rdata_q;
  assign fault         = fault_q;
endmodule
